// File: rtl/pipe_idexe_issue.sv
// ID->EXE issue stage: operand forwarding, load-use stall detection, E-stage
// registers, and a saturating count of inserted bubbles.
module pipe_idexe_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             dvalid,
    input  logic             dflush,
    input  logic [31:0]      da,
    input  logic [31:0]      db,
    input  logic [31:0]      dimm,
    input  logic [31:0]      dpc4,
    input  logic [4:0]       drs,
    input  logic [4:0]       drt,
    input  logic [4:0]       drn,
    input  logic             dusers,
    input  logic             dusert,
    input  logic [9:0]       dctrl,
    input  logic [31:0]      ealu,
    input  logic [31:0]      malu,
    input  logic [31:0]      mmo,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [4:0]       mrn,
    output logic [31:0]      ea,
    output logic [31:0]      eb,
    output logic [31:0]      eimm,
    output logic [31:0]      epc4,
    output logic [4:0]       ern0,
    output logic [9:0]       ectrl,
    output logic             evalid,
    output logic             stall,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [31:0]      r_ea_p1;
    logic [31:0]      r_eb_p1;
    logic [31:0]      r_eimm_p1;
    logic [31:0]      r_epc4_p1;
    logic [4:0]       r_ern0_p1;
    logic [9:0]       r_ectrl_p1;
    logic             r_vld_p1;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic             w_ewreg;
    logic             w_em2reg;
    logic [4:0]       w_ern;
    logic             w_hz;
    logic             w_bubble;
    logic             w_cnt_inc;
    logic [1:0]       w_fwda;
    logic [1:0]       w_fwdb;
    logic [31:0]      w_opa;
    logic [31:0]      w_opb;

    // E stage wins over M; a non-load in E is the only E source that can forward.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] x,
        input logic       e_ok,
        input logic [4:0] e_rn,
        input logic       m_wr,
        input logic       m_ld,
        input logic [4:0] m_rn
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (e_ok && (e_rn != 5'd0) && (e_rn == x))
            sel = 2'd1;
        else if (m_wr && (m_rn != 5'd0) && (m_rn == x))
            sel = m_ld ? 2'd3 : 2'd2;
        return sel;
    endfunction

    function automatic logic [31:0] opnd_mux(
        input logic [1:0]  sel,
        input logic [31:0] rf,
        input logic [31:0] e_res,
        input logic [31:0] m_res,
        input logic [31:0] m_load
    );
        logic [31:0] v;
        case (sel)
            2'd1:    v = e_res;
            2'd2:    v = m_res;
            2'd3:    v = m_load;
            default: v = rf;
        endcase
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign w_ewreg  = r_ectrl_p1[7];
    assign w_em2reg = r_ectrl_p1[8];
    // jal forces the destination to r31 without changing the registered ern0.
    assign w_ern    = r_ern0_p1 | {5{r_ectrl_p1[6]}};

    assign w_fwda = fwd_sel(drs, r_vld_p1 & w_ewreg & ~w_em2reg, w_ern, mwreg, mm2reg, mrn);
    assign w_fwdb = fwd_sel(drt, r_vld_p1 & w_ewreg & ~w_em2reg, w_ern, mwreg, mm2reg, mrn);
    assign w_opa  = opnd_mux(w_fwda, da, ealu, malu, mmo);
    assign w_opb  = opnd_mux(w_fwdb, db, ealu, malu, mmo);

    assign w_hz = dvalid & r_vld_p1 & w_ewreg & w_em2reg & (w_ern != 5'd0) &
                  ((dusers & (w_ern == drs)) | (dusert & (w_ern == drt)));

    assign w_bubble  = dflush | ~dvalid | w_hz;
    assign w_cnt_inc = dvalid & (w_hz | dflush);

    // ---- stage boundary: ID (p0) -> E (p1) ----
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ea_p1      <= '0;
            r_eb_p1      <= '0;
            r_eimm_p1    <= '0;
            r_epc4_p1    <= '0;
            r_ern0_p1    <= '0;
            r_ectrl_p1   <= '0;
            r_vld_p1     <= 1'b0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_bubble) begin
                r_ea_p1    <= '0;
                r_eb_p1    <= '0;
                r_eimm_p1  <= '0;
                r_epc4_p1  <= '0;
                r_ern0_p1  <= '0;
                r_ectrl_p1 <= '0;
                r_vld_p1   <= 1'b0;
            end else begin
                r_ea_p1    <= w_opa;
                r_eb_p1    <= w_opb;
                r_eimm_p1  <= dimm;
                r_epc4_p1  <= dpc4;
                r_ern0_p1  <= drn;
                r_ectrl_p1 <= dctrl;
                r_vld_p1   <= 1'b1;
            end
            if (w_cnt_inc)
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
        end
    end

    assign ea         = r_ea_p1;
    assign eb         = r_eb_p1;
    assign eimm       = r_eimm_p1;
    assign epc4       = r_epc4_p1;
    assign ern0       = r_ern0_p1;
    assign ectrl      = r_ectrl_p1;
    assign evalid     = r_vld_p1;
    assign stall      = w_hz & ~dflush;
    assign fwda       = w_fwda;
    assign fwdb       = w_fwdb;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_idexe_issue.sv
// Bench for pipe_idexe_issue: directed scenarios followed by random traffic,
// all checked against a behavioural model of the E stage.
module tb_pipe_idexe_issue;

    logic        clock = 1'b0;
    logic        resetn;
    logic        dvalid, dflush, dusers, dusert, mwreg, mm2reg;
    logic [31:0] da, db, dimm, dpc4, ealu, malu, mmo;
    logic [4:0]  drs, drt, drn, mrn;
    logic [9:0]  dctrl;

    logic [31:0] ea, eb, eimm, epc4;
    logic [4:0]  ern0;
    logic [9:0]  ectrl;
    logic        evalid, stall;
    logic [1:0]  fwda, fwdb;
    logic [15:0] bubble_cnt;

    logic [31:0] s_ea, s_eb, s_eimm, s_epc4;
    logic [4:0]  s_ern0;
    logic [9:0]  s_ectrl;
    logic        s_evalid, s_stall;
    logic [1:0]  s_fwda, s_fwdb;
    logic [1:0]  s_bubble_cnt;

    int checks = 0;
    int errors = 0;

    // Model of what the E stage currently holds.
    logic [31:0] m_ea, m_eb, m_eimm, m_epc4;
    logic [4:0]  m_ern0;
    logic [9:0]  m_ectrl;
    logic        m_evalid;
    int          m_cnt;

    always #5 clock = ~clock;

    pipe_idexe_issue #(.CNT_W(16)) u_dut (
        .clock(clock), .resetn(resetn), .dvalid(dvalid), .dflush(dflush),
        .da(da), .db(db), .dimm(dimm), .dpc4(dpc4), .drs(drs), .drt(drt),
        .drn(drn), .dusers(dusers), .dusert(dusert), .dctrl(dctrl),
        .ealu(ealu), .malu(malu), .mmo(mmo), .mwreg(mwreg), .mm2reg(mm2reg),
        .mrn(mrn), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0),
        .ectrl(ectrl), .evalid(evalid), .stall(stall), .fwda(fwda),
        .fwdb(fwdb), .bubble_cnt(bubble_cnt)
    );

    pipe_idexe_issue #(.CNT_W(2)) u_sat (
        .clock(clock), .resetn(resetn), .dvalid(dvalid), .dflush(dflush),
        .da(da), .db(db), .dimm(dimm), .dpc4(dpc4), .drs(drs), .drt(drt),
        .drn(drn), .dusers(dusers), .dusert(dusert), .dctrl(dctrl),
        .ealu(ealu), .malu(malu), .mmo(mmo), .mwreg(mwreg), .mm2reg(mm2reg),
        .mrn(mrn), .ea(s_ea), .eb(s_eb), .eimm(s_eimm), .epc4(s_epc4),
        .ern0(s_ern0), .ectrl(s_ectrl), .evalid(s_evalid), .stall(s_stall),
        .fwda(s_fwda), .fwdb(s_fwdb), .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] e_dest();
        return m_ectrl[6] ? 5'd31 : m_ern0;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] x);
        if (m_evalid && m_ectrl[7] && !m_ectrl[8] && e_dest() != 0 && e_dest() == x)
            return 2'd1;
        if (mwreg && mrn != 0 && mrn == x)
            return mm2reg ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    function automatic logic m_hz();
        logic [4:0] d;
        d = e_dest();
        return dvalid && m_evalid && m_ectrl[7] && m_ectrl[8] && d != 0 &&
               ((dusers && d == drs) || (dusert && d == drt));
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf);
        case (s)
            2'd1:    return ealu;
            2'd2:    return malu;
            2'd3:    return mmo;
            default: return rf;
        endcase
    endfunction

    function automatic int sat_of(input int c, input int maxv);
        return (c > maxv) ? maxv : c;
    endfunction

    task automatic model_clear();
        m_ea = 0; m_eb = 0; m_eimm = 0; m_epc4 = 0;
        m_ern0 = 0; m_ectrl = 0; m_evalid = 0;
    endtask

    task automatic check_regs(input string pfx);
        chk({pfx, "_ea"}, ea, m_ea);
        chk({pfx, "_eb"}, eb, m_eb);
        chk({pfx, "_eimm"}, eimm, m_eimm);
        chk({pfx, "_epc4"}, epc4, m_epc4);
        chk({pfx, "_ern0"}, 32'(ern0), 32'(m_ern0));
        chk({pfx, "_ectrl"}, 32'(ectrl), 32'(m_ectrl));
        chk({pfx, "_evalid"}, 32'(evalid), 32'(m_evalid));
        chk({pfx, "_cnt"}, 32'(bubble_cnt), 32'(sat_of(m_cnt, 65535)));
        chk({pfx, "_s_ea"}, s_ea, m_ea);
        chk({pfx, "_s_eb"}, s_eb, m_eb);
        chk({pfx, "_s_eimm"}, s_eimm, m_eimm);
        chk({pfx, "_s_epc4"}, s_epc4, m_epc4);
        chk({pfx, "_s_ern0"}, 32'(s_ern0), 32'(m_ern0));
        chk({pfx, "_s_ectrl"}, 32'(s_ectrl), 32'(m_ectrl));
        chk({pfx, "_s_evalid"}, 32'(s_evalid), 32'(m_evalid));
        chk({pfx, "_s_cnt"}, 32'(s_bubble_cnt), 32'(sat_of(m_cnt, 3)));
    endtask

    // Called just after a rising edge with the ID/M inputs already driven.
    task automatic step(input string pfx);
        logic [1:0] fa, fb;
        logic       hz;
        #1;
        fa = m_fwd(drs);
        fb = m_fwd(drt);
        hz = m_hz();
        chk({pfx, "_fwda"}, 32'(fwda), 32'(fa));
        chk({pfx, "_fwdb"}, 32'(fwdb), 32'(fb));
        chk({pfx, "_stall"}, 32'(stall), 32'(hz && !dflush));
        chk({pfx, "_s_fwda"}, 32'(s_fwda), 32'(fa));
        chk({pfx, "_s_fwdb"}, 32'(s_fwdb), 32'(fb));
        chk({pfx, "_s_stall"}, 32'(s_stall), 32'(hz && !dflush));
        if (dflush || !dvalid || hz) begin
            if (dvalid && (hz || dflush)) m_cnt++;
            model_clear();
        end else begin
            m_ea = pick(fa, da); m_eb = pick(fb, db);
            m_eimm = dimm; m_epc4 = dpc4; m_ern0 = drn;
            m_ectrl = dctrl; m_evalid = 1'b1;
        end
        @(posedge clock);
        #1;
        check_regs(pfx);
    endtask

    task automatic idle();
        dvalid = 0; dflush = 0; dusers = 0; dusert = 0;
        da = 0; db = 0; dimm = 0; dpc4 = 0; drs = 0; drt = 0; drn = 0; dctrl = 0;
        ealu = 0; malu = 0; mmo = 0; mwreg = 0; mm2reg = 0; mrn = 0;
    endtask

    task automatic issue(input logic [9:0] ctrl, input logic [4:0] rn,
                         input logic [4:0] rs, input logic [4:0] rt);
        dvalid = 1; dflush = 0; dctrl = ctrl; drn = rn; drs = rs; drt = rt;
        dusers = 1; dusert = 1;
        dimm = $urandom; dpc4 = $urandom; da = $urandom; db = $urandom;
    endtask

    localparam logic [9:0] C_ALU  = 10'h080;
    localparam logic [9:0] C_LOAD = 10'h180;
    localparam logic [9:0] C_JAL  = 10'h0C0;

    logic [4:0] regs [5];

    initial begin
        regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd2; regs[3] = 5'd3; regs[4] = 5'd31;
        idle();
        resetn = 0;
        model_clear();
        m_cnt = 0;
        repeat (2) @(posedge clock);
        #1;
        check_regs("rst");
        resetn = 1;

        // Back-to-back ALU forwarding from E.
        issue(C_ALU, 5'd5, 5'd1, 5'd2);
        step("alu0");
        issue(C_ALU, 5'd6, 5'd5, 5'd2);
        da = 32'h0; ealu = 32'h11;
        #1;
        chk("alu_fwda", 32'(fwda), 32'd1);
        chk("alu_stall", 32'(stall), 32'd0);
        step("alu1");
        chk("alu_ea", ea, 32'h11);
        chk("alu_evalid", 32'(evalid), 32'd1);

        // Load-use: one stall, then forward the load data from M.
        issue(C_LOAD, 5'd8, 5'd1, 5'd2);
        step("lu0");
        issue(C_ALU, 5'd9, 5'd8, 5'd2);
        dusert = 0;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        step("lu1");
        chk("lu_evalid", 32'(evalid), 32'd0);
        chk("lu_ectrl", 32'(ectrl), 32'd0);
        chk("lu_cnt", 32'(bubble_cnt), 32'd1);
        mwreg = 1; mm2reg = 1; mrn = 5'd8; mmo = 32'hDEADBEEF;
        #1;
        chk("lu_fwda3", 32'(fwda), 32'd3);
        chk("lu_stall2", 32'(stall), 32'd0);
        step("lu2");
        chk("lu_ea", ea, 32'hDEADBEEF);

        // E-over-M priority, then r0 never forwarded.
        idle();
        issue(C_ALU, 5'd3, 5'd1, 5'd2);
        step("pr0");
        issue(C_ALU, 5'd0, 5'd3, 5'd3);
        mwreg = 1; mm2reg = 0; mrn = 5'd3; ealu = 32'd1; malu = 32'd2;
        #1;
        chk("pr_fwda", 32'(fwda), 32'd1);
        step("pr1");
        chk("pr_ea", ea, 32'd1);
        issue(C_ALU, 5'd4, 5'd0, 5'd0);
        da = 32'd7; mwreg = 1; mm2reg = 0; mrn = 5'd0; ealu = 32'd1; malu = 32'd2;
        #1;
        chk("r0_fwda", 32'(fwda), 32'd0);
        step("r0");
        chk("r0_ea", ea, 32'd7);

        // Flush during a load-use hazard: no stall, bubble counted.
        idle();
        issue(C_LOAD, 5'd4, 5'd1, 5'd2);
        step("fl0");
        issue(C_ALU, 5'd6, 5'd4, 5'd2);
        dflush = 1;
        #1;
        chk("fl_stall", 32'(stall), 32'd0);
        step("fl1");
        chk("fl_evalid", 32'(evalid), 32'd0);
        chk("fl_cnt", 32'(bubble_cnt), 32'd2);

        // jal writes r31 even though drn is 0.
        idle();
        issue(C_JAL, 5'd0, 5'd1, 5'd2);
        step("jal0");
        chk("jal_ern0", 32'(ern0), 32'd0);
        issue(C_ALU, 5'd7, 5'd31, 5'd2);
        ealu = 32'hCAFE0001;
        #1;
        chk("jal_fwda", 32'(fwda), 32'd1);
        step("jal1");
        chk("jal_ea", ea, 32'hCAFE0001);

        // Asynchronous reset between edges while E holds a real instruction.
        chk("mr_pre_evalid", 32'(evalid), 32'd1);
        #2;
        resetn = 0;
        #1;
        model_clear();
        m_cnt = 0;
        check_regs("mr");
        @(posedge clock);
        #1;
        resetn = 1;

        // Five flush bubbles saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            issue(C_ALU, 5'd1, 5'd2, 5'd3);
            dflush = 1;
            step("sat");
        end
        chk("sat_small", 32'(s_bubble_cnt), 32'd3);
        chk("sat_big", 32'(bubble_cnt), 32'd5);

        // Random traffic with a small register pool to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            dvalid = ($urandom_range(0, 4) != 0);
            dflush = ($urandom_range(0, 7) == 0);
            da = $urandom; db = $urandom; dimm = $urandom; dpc4 = $urandom;
            drs = regs[$urandom_range(0, 4)];
            drt = regs[$urandom_range(0, 4)];
            drn = regs[$urandom_range(0, 4)];
            dusers = $urandom_range(0, 1);
            dusert = $urandom_range(0, 1);
            dctrl = 10'($urandom);
            ealu = $urandom; malu = $urandom; mmo = $urandom;
            mwreg = $urandom_range(0, 1);
            mm2reg = $urandom_range(0, 1);
            mrn = regs[$urandom_range(0, 4)];
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_idexe_issue.md
Name: pipe_idexe_issue

Overview:
- ID→EXE issue stage of the 5-stage pipeline; the producer that drives every input of the execute stage.
- Selects forwarded operands for rs/rt, detects load-use hazards and raises stall toward IF/ID.
- Registers the decoded instruction, or a bubble, into the E-stage registers.
- Counts inserted bubbles for performance monitoring.

Parameters:
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clock  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous active-low reset
- dvalid  in  1  ID stage holds a real instruction
- dflush  in  1  discard ID instruction this cycle (redirect)
- da  in  32  register-file rs read data
- db  in  32  register-file rt read data
- dimm  in  32  extended immediate
- dpc4  in  32  PC+4 of ID instruction
- drs  in  5  rs index
- drt  in  5  rt index
- drn  in  5  destination index before jal override
- dusers  in  1  instruction reads rs
- dusert  in  1  instruction reads rt (includes stores)
- dctrl  in  10  [3:0] aluc, [4] aluimm, [5] shift, [6] jal, [7] wreg, [8] m2reg, [9] wmem
- ealu  in  32  current EXE result (combinational from execute stage)
- malu  in  32  MEM-stage ALU result
- mmo  in  32  MEM-stage load data
- mwreg  in  1  MEM instruction writes a register
- mm2reg  in  1  MEM instruction is a load
- mrn  in  5  MEM destination index
- ea  out  32  registered operand A
- eb  out  32  registered operand B
- eimm  out  32  registered immediate
- epc4  out  32  registered PC+4
- ern0  out  5  registered destination index
- ectrl  out  10  registered control, same layout as dctrl
- evalid  out  1  E stage holds a real instruction
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- fwda  out  2  rs source select: 0 regfile, 1 ealu, 2 malu, 3 mmo (combinational)
- fwdb  out  2  rt source select, same encoding (combinational)
- bubble_cnt  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (async, resetn=0): all registered outputs and bubble_cnt cleared to 0 immediately, regardless of clock. A mid-cycle reset discards the in-flight E instruction.
- Internal E state: ewreg=ectrl[7], em2reg=ectrl[8], ern = ern0 | {5{ectrl[6]}}. A jal targets r31.
- Forwarding, per operand X in {rs,rt}:
  - fwd=1 if evalid & ewreg & ~em2reg & ern!=0 & ern==X.
  - Else fwd = mm2reg?3:2 if mwreg & mrn!=0 & mrn==X.
  - Else fwd=0.
  - E stage has priority over M. Register 0 is never forwarded.
- Load-use hazard: hz = dvalid & evalid & ewreg & em2reg & ern!=0 & ((dusers & ern==drs) | (dusert & ern==drt)).
- stall = hz & ~dflush. A flush cancels the ID instruction, so no stall is needed.
- Each rising edge, priority order:
  - (1) dflush or ~dvalid or hz → bubble: ectrl=0, evalid=0, ea/eb/eimm/epc4/ern0=0.
  - (2) otherwise issue: ea/eb = selected forward value, eimm=dimm, epc4=dpc4, ern0=drn, ectrl=dctrl, evalid=1.
- bubble_cnt increments on every bubble caused by hz or dflush with dvalid=1. It holds at all-ones.
- Stall lasts exactly 1 cycle per load-use pair. The load then moves to M, and the next cycle forwards via fwd=3.
- Latency: 1 cycle from ID inputs to E outputs. No combinational path from d* inputs to registered outputs.

Test Plan:
- Reset mid-run: assert resetn=0 between edges with evalid=1 → all outputs 0 within the same cycle; bubble_cnt=0.
- Back-to-back ALU: E add r5 = ealu 0x00000011; ID uses rs=5, da=0 → fwda=1; next edge ea=0x11, evalid=1, stall=0.
- Load-use: E lw r8 (em2reg=1); ID add rs=8.
  - Cycle 1: stall=1, bubble issued (evalid=0, ectrl=0), bubble_cnt=1.
  - Cycle 2: mwreg=1, mm2reg=1, mrn=8, mmo=0xDEADBEEF → fwda=3, ea=0xDEADBEEF.
- Priority and r0: E and M both write r3 (ealu=1, malu=2) → fwda=1. With both writing r0 and da=7 → fwda=0, ea=7.
- Flush during hazard: hz condition true and dflush=1 → stall=0, bubble issued, bubble_cnt increments.
- jal: dctrl[6]=1, drn=0 issues → ern0=0, internal ern=31. A following instruction with rs=31 gets fwda=1.
- Counter saturation: CNT_W=2 with 5 consecutive bubbles → bubble_cnt=3.
